// File: rtl/vga_timing_gen.sv
// VGA pixel-timing master: free-running scan counters, sync/blank decodes with a
// configurable delay line to match the colour stage, and a per-frame tick/counter.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIPE_DLY = 1
) (
    input  logic       pixel_clk,
    input  logic       Reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       active,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    // 11-bit bounds so a total of exactly 1024 cannot alias to zero
    localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [2:0]  IDLE_HVB = 3'b110;

    function automatic logic dec_active(input logic [9:0] h, input logic [9:0] v);
        return ({1'b0, h} < H_ACT) && ({1'b0, v} < V_ACT);
    endfunction

    function automatic logic dec_hs(input logic [9:0] h);
        return !(({1'b0, h} >= HS_BEG) && ({1'b0, h} < HS_END));
    endfunction

    function automatic logic dec_vs(input logic [9:0] v);
        return !(({1'b0, v} >= VS_BEG) && ({1'b0, v} < VS_END));
    endfunction

    function automatic logic dec_fs(input logic [9:0] h, input logic [9:0] v);
        return (h == 10'd0) && ({1'b0, v} == V_ACT);
    endfunction

    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic       active_q, active_d;
    logic       hs_raw_q, hs_raw_d;
    logic       vs_raw_q, vs_raw_d;
    logic       fs_q, fs_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;

    // Next-state counters; decodes are taken from next state so they line up with hc/vc
    always_comb begin
        hc_d        = hc_q;
        vc_d        = vc_q;
        frame_cnt_d = frame_cnt_q;
        if (hc_q == H_LAST) begin
            hc_d = 10'd0;
            if (vc_q == V_LAST) begin
                vc_d = 10'd0;
            end else begin
                vc_d = vc_q + 10'd1;
            end
        end else begin
            hc_d = hc_q + 10'd1;
        end
        if (fs_q) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
        active_d = dec_active(hc_d, vc_d);
        hs_raw_d = dec_hs(hc_d);
        vs_raw_d = dec_vs(vc_d);
        fs_d     = dec_fs(hc_d, vc_d);
    end

    // Counter and decode registers
    always_ff @(posedge pixel_clk) begin
        if (Reset) begin
            hc_q        <= 10'd0;
            vc_q        <= 10'd0;
            frame_cnt_q <= 8'd0;
            active_q    <= dec_active(10'd0, 10'd0);
            hs_raw_q    <= dec_hs(10'd0);
            vs_raw_q    <= dec_vs(10'd0);
            fs_q        <= dec_fs(10'd0, 10'd0);
        end else begin
            hc_q        <= hc_d;
            vc_q        <= vc_d;
            frame_cnt_q <= frame_cnt_d;
            active_q    <= active_d;
            hs_raw_q    <= hs_raw_d;
            vs_raw_q    <= vs_raw_d;
            fs_q        <= fs_d;
        end
    end

    assign DrawX       = hc_q;
    assign DrawY       = vc_q;
    assign active      = active_q;
    assign frame_start = fs_q;
    assign frame_cnt   = frame_cnt_q;

    generate
        if (PIPE_DLY == 0) begin : g_pass
            assign {hs, vs, blank} = {hs_raw_q, vs_raw_q, active_q};
        end else begin : g_dly
            logic [2:0] stage_q [PIPE_DLY];

            // Sync/blank delay line; reset loads idle so a pulse in flight is dropped
            always_ff @(posedge pixel_clk) begin
                if (Reset) begin
                    for (int i = 0; i < PIPE_DLY; i++) begin
                        stage_q[i] <= IDLE_HVB;
                    end
                end else begin
                    stage_q[0] <= {hs_raw_q, vs_raw_q, active_q};
                    for (int i = 1; i < PIPE_DLY; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign {hs, vs, blank} = stage_q[PIPE_DLY-1];
        end
    endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: arithmetic scan model checked every cycle on three
// configurations, plus literal spot checks at line, sync, frame and reset boundaries.
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       rst;
    int         tests = 0;
    int         fails = 0;
    int         t     = 0;
    bit         valid = 1'b0;

    logic [9:0] d_x, d_y, p0_x, p0_y, p3_x, p3_y;
    logic       d_act, d_hs, d_vs, d_bl, d_fs;
    logic       p0_act, p0_hs, p0_vs, p0_bl, p0_fs;
    logic       p3_act, p3_hs, p3_vs, p3_bl, p3_fs;
    logic [7:0] d_fc, p0_fc, p3_fc;

    always #5 clk = ~clk;

    vga_timing_gen u_def (
        .pixel_clk(clk), .Reset(rst), .DrawX(d_x), .DrawY(d_y), .active(d_act),
        .hs(d_hs), .vs(d_vs), .blank(d_bl), .frame_start(d_fs), .frame_cnt(d_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_DLY(0)
    ) u_p0 (
        .pixel_clk(clk), .Reset(rst), .DrawX(p0_x), .DrawY(p0_y), .active(p0_act),
        .hs(p0_hs), .vs(p0_vs), .blank(p0_bl), .frame_start(p0_fs), .frame_cnt(p0_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_DLY(3)
    ) u_p3 (
        .pixel_clk(clk), .Reset(rst), .DrawX(p3_x), .DrawY(p3_y), .active(p3_act),
        .hs(p3_hs), .vs(p3_vs), .blank(p3_bl), .frame_start(p3_fs), .frame_cnt(p3_fc)
    );

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", name, got, exp, t);
        end
    endtask

    // Expected outputs t cycles after the last reset edge, from plain scan arithmetic
    function automatic void model(input int tt, input int ha, input int hf, input int hsw,
                                  input int hb, input int va, input int vf, input int vsw,
                                  input int vb, input int d,
                                  output int x, output int y, output int act, output int h,
                                  output int v, output int b, output int fs, output int fc);
        int ht, vt, s, sx, sy;
        ht  = ha + hf + hsw + hb;
        vt  = va + vf + vsw + vb;
        x   = tt % ht;
        y   = (tt / ht) % vt;
        act = (x < ha && y < va) ? 1 : 0;
        fs  = (x == 0 && y == va) ? 1 : 0;
        fc  = (tt <= va * ht) ? 0 : (((tt - va * ht - 1) / (ht * vt) + 1) % 256);
        s   = tt - d;
        if (s < 0) begin
            h = 1; v = 1; b = 0;
        end else begin
            sx = s % ht;
            sy = (s / ht) % vt;
            h  = (sx >= ha + hf && sx < ha + hf + hsw) ? 0 : 1;
            v  = (sy >= va + vf && sy < va + vf + vsw) ? 0 : 1;
            b  = (sx < ha && sy < va) ? 1 : 0;
        end
    endfunction

    task automatic check_unit(input string tag, input int ha, input int hf, input int hsw,
                              input int hb, input int va, input int vf, input int vsw,
                              input int vb, input int d,
                              input logic [9:0] x, input logic [9:0] y, input logic act,
                              input logic h, input logic v, input logic b, input logic fs,
                              input logic [7:0] fc);
        int ex, ey, ea, eh, ev, eb, ef, ec;
        model(t, ha, hf, hsw, hb, va, vf, vsw, vb, d, ex, ey, ea, eh, ev, eb, ef, ec);
        chk({tag, ".DrawX"}, int'(x), ex);
        chk({tag, ".DrawY"}, int'(y), ey);
        chk({tag, ".active"}, int'(act), ea);
        chk({tag, ".hs"}, int'(h), eh);
        chk({tag, ".vs"}, int'(v), ev);
        chk({tag, ".blank"}, int'(b), eb);
        chk({tag, ".frame_start"}, int'(fs), ef);
        chk({tag, ".frame_cnt"}, int'(fc), ec);
    endtask

    // Cycle index since the most recent reset edge
    always @(posedge clk) begin
        if (rst) begin
            t     <= 0;
            valid <= 1'b1;
        end else begin
            t <= t + 1;
        end
    end

    // Per-cycle comparison of every configuration against the model
    always @(negedge clk) begin
        if (valid) begin
            check_unit("def", 640, 16, 96, 48, 480, 10, 2, 33, 1,
                       d_x, d_y, d_act, d_hs, d_vs, d_bl, d_fs, d_fc);
            check_unit("p0", 4, 1, 2, 1, 4, 1, 2, 1, 0,
                       p0_x, p0_y, p0_act, p0_hs, p0_vs, p0_bl, p0_fs, p0_fc);
            check_unit("p3", 4, 1, 2, 1, 4, 1, 2, 1, 3,
                       p3_x, p3_y, p3_act, p3_hs, p3_vs, p3_bl, p3_fs, p3_fc);
        end
    end

    task automatic goto(input int target);
        if (t > target) begin
            chk("goto_overrun", t, target);
        end
        while (t < target) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset release
        goto(0);
        chk("rel.DrawX", int'(d_x), 0);
        chk("rel.DrawY", int'(d_y), 0);
        chk("rel.active", int'(d_act), 1);
        chk("rel.hs", int'(d_hs), 1);
        chk("rel.vs", int'(d_vs), 1);
        chk("rel.blank", int'(d_bl), 0);
        chk("rel.frame_cnt", int'(d_fc), 0);
        chk("rel.p0_blank", int'(p0_bl), 1);
        goto(1);
        chk("rel2.blank", int'(d_bl), 1);
        chk("rel2.p3_blank", int'(p3_bl), 0);
        goto(3);
        chk("rel4.p3_blank", int'(p3_bl), 1);

        // Active edge and horizontal sync on line 0
        goto(639);  chk("h639.active", int'(d_act), 1);
        goto(640);  chk("h640.active", int'(d_act), 0);
        goto(656);  chk("h656.hs", int'(d_hs), 1);
        goto(657);  chk("h657.hs", int'(d_hs), 0);
        goto(752);  chk("h752.hs", int'(d_hs), 0);
        goto(753);  chk("h753.hs", int'(d_hs), 1);

        // Line wrap
        goto(799);
        chk("h799.DrawX", int'(d_x), 799);
        chk("h799.DrawY", int'(d_y), 0);
        chk("h799.active", int'(d_act), 0);
        goto(800);
        chk("h800.DrawX", int'(d_x), 0);
        chk("h800.DrawY", int'(d_y), 1);
        chk("h800.active", int'(d_act), 1);

        // Reset in the middle of an hsync pulse on line 10
        goto(8700);
        chk("mid.DrawX", int'(d_x), 700);
        chk("mid.DrawY", int'(d_y), 10);
        chk("mid.hs", int'(d_hs), 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst.DrawX", int'(d_x), 0);
        chk("mid_rst.DrawY", int'(d_y), 0);
        chk("mid_rst.hs", int'(d_hs), 1);
        chk("mid_rst.frame_cnt", int'(d_fc), 0);
        chk("mid_rst.p0_frame_cnt", int'(p0_fc), 0);
        rst = 1'b0;

        // Small-frame instances: 8x8 totals, frame_start at line 4
        goto(31);   chk("f31.p0_fs", int'(p0_fs), 0);
        goto(32);
        chk("f32.p0_fs", int'(p0_fs), 1);
        chk("f32.p0_DrawY", int'(p0_y), 4);
        chk("f32.p0_blank", int'(p0_bl), 0);
        goto(33);
        chk("f33.p0_fs", int'(p0_fs), 0);
        chk("f33.p0_frame_cnt", int'(p0_fc), 1);
        goto(39);   chk("v39.p0_vs", int'(p0_vs), 1);
        goto(40);   chk("v40.p0_vs", int'(p0_vs), 0);
        chk("v40.p3_vs", int'(p3_vs), 1);
        goto(43);   chk("v43.p3_vs", int'(p3_vs), 0);
        goto(55);   chk("v55.p0_vs", int'(p0_vs), 0);
        goto(56);   chk("v56.p0_vs", int'(p0_vs), 1);
        goto(64);   chk("w64.p0_DrawY", int'(p0_y), 0);
        goto(16352); chk("wrap.p0_frame_cnt_255", int'(p0_fc), 255);
        goto(16353);
        chk("wrap.p0_frame_cnt_0", int'(p0_fc), 0);
        chk("wrap.p3_frame_cnt_0", int'(p3_fc), 0);
        goto(16360);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
